// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin scheduler in front of an 8N1-style
// serial transmitter. It accepts one byte per valid/ready handshake, and only
// while idle. The line and busy outputs come straight from flops.
module uart_tx_sched #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             uart_tx_line,
    output logic             busy,
    output logic             grant_id
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cyc_q, cyc_n;
    logic [BW-1:0]    bit_q, bit_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic             grant_q, grant_n;
    logic             line_q, line_n;
    logic             busy_q, busy_n;

    logic sel;
    logic offer;
    logic accept;
    logic bit_end;

    // Round-robin pick: on a tie, the requester that was not served last wins.
    // With a single valid requester, that requester is picked. Offers are made
    // only while idle and out of reset.
    always_comb begin
        sel    = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
        offer  = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        accept = offer;
    end

    assign req0_ready   = offer && !sel;
    assign req1_ready   = offer && sel;
    assign uart_tx_line = line_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign bit_end      = (cyc_q == CYC_LAST);

    // Next-state logic. The registered line/busy values are computed for the
    // state being entered, so the outputs change exactly on bit boundaries.
    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        grant_n = grant_q;
        line_n  = line_q;
        busy_n  = busy_q;
        case (state_q)
            IDLE: begin
                line_n = 1'b1;
                busy_n = 1'b0;
                if (accept) begin
                    shift_n = sel ? req1_data : req0_data;
                    grant_n = sel;
                    state_n = START;
                    cyc_n   = '0;
                    bit_n   = '0;
                    line_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cyc_n   = '0;
                    bit_n   = '0;
                    line_n  = shift_q[0];
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    shift_n = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_n = STOP;
                        bit_n   = '0;
                        line_n  = 1'b1;
                    end else begin
                        bit_n  = bit_q + 1'b1;
                        line_n = shift_n[0];
                    end
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    line_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                bit_n   = '0;
                line_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State register. A reset abandons any frame in flight; grant_id resets
    // to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            grant_q <= 1'b1;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cyc_q   <= cyc_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            grant_q <= grant_n;
            line_q  <= line_n;
            busy_q  <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a default build (CLKS_PER_BIT=2) and a
// CLKS_PER_BIT=1 build, driven and sampled on the falling clock edge.
module tb_uart_tx_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, line_a, busy_a, grant_a;
    logic       req0_valid_b, req1_valid_b;
    logic [7:0] req0_data_b, req1_data_b;
    logic       req0_ready_b, req1_ready_b, line_b, busy_b, grant_b;

    int nvec = 0;
    int nerr = 0;

    uart_tx_sched #(.WIDTH(8), .CLKS_PER_BIT(2)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_tx_line(line_a), .busy(busy_a), .grant_id(grant_a)
    );

    uart_tx_sched #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid_b), .req0_data(req0_data_b), .req0_ready(req0_ready_b),
        .req1_valid(req1_valid_b), .req1_data(req1_data_b), .req1_ready(req1_ready_b),
        .uart_tx_line(line_b), .busy(busy_b), .grant_id(grant_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one whole frame starting at the START cycle after an accept.
    // Called at the negedge of the accept cycle (or just after its posedge).
    task automatic frame(input string tag, input bit use_b, input logic [7:0] data, input int cpb);
        logic [7:0] dec;
        logic       exp_bit, ln, bz, r0, r1;
        dec = '0;
        for (int i = 0; i < 10; i++) begin
            exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : data[i-1];
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                ln = use_b ? line_b : line_a;
                bz = use_b ? busy_b : busy_a;
                r0 = use_b ? req0_ready_b : req0_ready;
                r1 = use_b ? req1_ready_b : req1_ready;
                chk({tag, " line"}, 32'(ln), 32'(exp_bit));
                chk({tag, " busy"}, 32'(bz), 32'd1);
                chk({tag, " ready0 in frame"}, 32'(r0), 32'd0);
                chk({tag, " ready1 in frame"}, 32'(r1), 32'd0);
                if (i >= 1 && i <= 8 && c == 0) dec[i-1] = ln;
            end
        end
        chk({tag, " decoded byte"}, 32'(dec), 32'(data));
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        req0_valid_b = 0; req1_valid_b = 0; req0_data_b = '0; req1_data_b = '0;
        repeat (2) @(negedge clk);

        // Reset state, with req0 already asserting valid
        req0_valid = 1; req0_data = 8'h01;
        #1;
        chk("rst line", 32'(line_a), 32'd1);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst grant", 32'(grant_a), 32'd1);
        chk("rst ready0", 32'(req0_ready), 32'd0);

        // Lone req0 with 0x01
        @(negedge clk); rst = 1'b0; #1;
        chk("s1 ready0", 32'(req0_ready), 32'd1);
        chk("s1 ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1 req0_valid = 0;
        frame("s1 0x01", 1'b0, 8'h01, 2);
        chk("s1 grant", 32'(grant_a), 32'd0);
        @(negedge clk);
        chk("s1 idle busy", 32'(busy_a), 32'd0);
        chk("s1 idle line", 32'(line_a), 32'd1);

        // Contention from reset: 0x03 (req0), 0x05 (req1), 0x03
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req0_valid = 1; req0_data = 8'h03; req1_valid = 1; req1_data = 8'h05; #1;
        chk("s2 first ready0", 32'(req0_ready), 32'd1);
        chk("s2 first ready1", 32'(req1_ready), 32'd0);
        frame("s2 f1", 1'b0, 8'h03, 2);
        chk("s2 f1 grant", 32'(grant_a), 32'd0);
        @(negedge clk);
        chk("s2 second ready1", 32'(req1_ready), 32'd1);
        chk("s2 second ready0", 32'(req0_ready), 32'd0);
        frame("s2 f2", 1'b0, 8'h05, 2);
        chk("s2 f2 grant", 32'(grant_a), 32'd1);
        @(negedge clk);
        chk("s2 third ready0", 32'(req0_ready), 32'd1);
        frame("s2 f3", 1'b0, 8'h03, 2);
        chk("s2 f3 grant", 32'(grant_a), 32'd0);
        req0_valid = 0; req1_valid = 0;

        // Lone req1 with 0xA5, back to back
        @(negedge clk);
        chk("s3 idle line", 32'(line_a), 32'd1);
        req1_valid = 1; req1_data = 8'hA5; #1;
        chk("s3 ready1", 32'(req1_ready), 32'd1);
        chk("s3 ready0", 32'(req0_ready), 32'd0);
        frame("s3 f1", 1'b0, 8'hA5, 2);
        @(negedge clk);
        chk("s3 gap line", 32'(line_a), 32'd1);
        chk("s3 gap busy", 32'(busy_a), 32'd0);
        chk("s3 gap ready1", 32'(req1_ready), 32'd1);
        chk("s3 gap ready0", 32'(req0_ready), 32'd0);
        frame("s3 f2", 1'b0, 8'hA5, 2);
        chk("s3 grant", 32'(grant_a), 32'd1);
        req1_valid = 0;

        // Reset during data bit 3 of a 0xFF frame
        @(negedge clk);
        req0_valid = 1; req0_data = 8'hFF;
        @(posedge clk); #1 req0_valid = 0;
        repeat (9) @(negedge clk);
        chk("s4 mid busy", 32'(busy_a), 32'd1);
        chk("s4 mid grant", 32'(grant_a), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("s4 rst line", 32'(line_a), 32'd1);
        chk("s4 rst busy", 32'(busy_a), 32'd0);
        chk("s4 rst grant", 32'(grant_a), 32'd1);
        @(negedge clk); rst = 1'b0;
        req0_valid = 1; req0_data = 8'h07; #1;
        chk("s4 ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1 req0_valid = 0;
        frame("s4 0x07", 1'b0, 8'h07, 2);

        // req0 single-cycle pulse inside a req1 frame is ignored
        @(negedge clk);
        req1_valid = 1; req1_data = 8'h5A; #1;
        chk("s5 ready1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1 req1_valid = 0;
        req0_valid = 1; req0_data = 8'h33; #1;
        chk("s5 pulse ready0", 32'(req0_ready), 32'd0);
        @(posedge clk); #1 req0_valid = 0;
        repeat (19) @(negedge clk);
        chk("s5 stop line", 32'(line_a), 32'd1);
        chk("s5 stop busy", 32'(busy_a), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s5 after line", 32'(line_a), 32'd1);
            chk("s5 after busy", 32'(busy_a), 32'd0);
        end

        // CLKS_PER_BIT=1 build, bytes 1,3,5,7,9 on req0
        req0_valid_b = 1;
        for (int k = 0; k < 5; k++) begin
            req0_data_b = 8'(2 * k + 1);
            if (k > 0) @(negedge clk);
            #1;
            chk("s6 ready0", 32'(req0_ready_b), 32'd1);
            frame("s6 frame", 1'b1, 8'(2 * k + 1), 1);
        end
        req0_valid_b = 0;
        @(negedge clk);
        chk("s6 idle busy", 32'(busy_b), 32'd0);
        chk("s6 idle line", 32'(line_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single serial transmit line between two byte producers: requester 0 (the CPU output port) and requester 1 (the debug/monitor source).
- Arbitrates between them with round-robin priority.
- Accepts one byte per valid/ready handshake.
- Serialises the byte as an 8N1-style frame: start bit, WIDTH data bits LSB first, one stop bit.
- Sits between the CPU core's output register and the top-level uart_tx_line pin.

Parameters:
- WIDTH, 8, data bits per frame and width of each requester data bus.
- CLKS_PER_BIT, 2, clk cycles each serial bit is held on the line; legal range is 1 or greater.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a byte to send.
- req0_data  input  WIDTH  requester 0 byte.
- req0_ready  output  1  requester 0 byte is accepted in this cycle if req0_valid is high.
- req1_valid  input  1  requester 1 has a byte to send.
- req1_data  input  WIDTH  requester 1 byte.
- req1_ready  output  1  requester 1 byte is accepted in this cycle if req1_valid is high.
- uart_tx_line  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- grant_id  output  1  index of the requester whose frame is in progress, or that was last served.

Behaviour:
- Reset values:
  - state is IDLE.
  - uart_tx_line = 1.
  - busy = 0.
  - grant_id = 1, so requester 0 wins the first tie.
  - Bit counter, cycle counter and shift register are 0.
  - Both ready outputs are 0 during the reset cycle.
- Arbitration: combinational, evaluated only in IDLE.
  - If exactly one valid is high, that requester is selected.
  - If both are high, the requester other than grant_id is selected.
  - readyN = (state==IDLE) && !rst && selected==N. At most one ready is high in any cycle.
  - A requester with valid low is never granted.
- Accept cycle: valid && ready.
  - Data is latched into the shift register.
  - grant_id is updated to the selected requester.
  - Next state is START.
  - valid may drop after the accept cycle without effect.
  - Data must hold only during the accept cycle.
- States and transitions:
  - IDLE: line = 1, busy = 0. Moves to START on accept.
  - START: line = 0, busy = 1. Held for CLKS_PER_BIT cycles, then DATA.
  - DATA: line = shift register bit 0. The register shifts right every CLKS_PER_BIT cycles. After WIDTH bits, moves to STOP.
  - STOP: line = 1, busy = 1. Held for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - Frame occupies (WIDTH+2)*CLKS_PER_BIT cycles, starting the cycle after accept.
  - The earliest next accept is the first IDLE cycle after STOP.
  - The minimum spacing between accept cycles is therefore (WIDTH+2)*CLKS_PER_BIT+1 cycles.
- Output timing: uart_tx_line and busy are registered and glitch-free. The line changes only on bit boundaries.
- Counter widths:
  - Cycle counter is $clog2(CLKS_PER_BIT)+1 bits.
  - Bit counter is $clog2(WIDTH)+1 bits.
  - Both reset to 0 at every state entry.
  - No wrap-around occurs within a bit or frame.
- Valid changes during a frame are ignored. Requesters simply wait with ready low.
- Reset asserted mid-frame:
  - The frame is abandoned.
  - The line returns to 1 on the next edge.
  - All state returns to reset values.
  - No partial byte is resumed.
- Round-robin:
  - Under continuous contention, grants strictly alternate 0, 1, 0, 1...
  - A lone requester is served back-to-back with no idle penalty beyond the single IDLE cycle.

Test Plan:
- Reset, then req0_valid=1 with data 0x01, req1 idle:
  - req0_ready=1 in the first post-reset cycle.
  - Line shows 0, then 1,0,0,0,0,0,0,0, then 1, each bit held 2 cycles.
  - busy is high for 20 cycles.
- Both valid from reset, req0=0x03 and req1=0x05, held:
  - First frame is 0x03 with grant_id=0.
  - Second frame is 0x05 with grant_id=1.
  - Third frame is 0x03 again.
  - Accept cycles are 21 cycles apart.
- Only req1 valid continuously with 0xA5:
  - Consecutive frames 0xA5, 0xA5.
  - req0_ready is never high.
  - Gap between frames is exactly 1 idle cycle with line=1.
- Assert rst during DATA bit 3 of a 0xFF frame:
  - Line=1 and busy=0 on the next edge.
  - grant_id=1.
  - A new req0 byte 0x07 is then sent as a complete, correct frame.
- req0_valid pulsed for a single cycle during a req1 frame:
  - The pulse is not accepted: req0_ready stays 0 and no frame follows.
  - The line stays 1 after the req1 stop bit.
- CLKS_PER_BIT=1 build, byte 0x09 (odd values 1,3,5,7,9 in sequence):
  - Each frame lasts 10 cycles.
  - The decoded bytes match 1,3,5,7,9 exactly.
